// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_pkg: shared types, widths and helpers for the 7-segment scan controller.
package seven_seg_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {S_BLANK, S_DRIVE} scan_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: application-side load/enable inputs and decoder/digit-select outputs.
interface seven_seg_scan_ctrl_if #(parameter int NUM_DIGITS = 4);

    import seven_seg_pkg::*;

    logic                           i_EN;
    logic                           i_Load;
    logic [NIBBLE_W*NUM_DIGITS-1:0] i_Digits;
    logic                           o_Load_Ack;
    logic [NIBBLE_W-1:0]            o_Binary_Num;
    logic                           o_EN;
    logic [NUM_DIGITS-1:0]          o_Digit_Sel;
    logic                           o_Frame_Start;

    modport master (
        output i_EN, i_Load, i_Digits,
        input  o_Load_Ack, o_Binary_Num, o_EN, o_Digit_Sel, o_Frame_Start
    );

    modport slave (
        input  i_EN, i_Load, i_Digits,
        output o_Load_Ack, o_Binary_Num, o_EN, o_Digit_Sel, o_Frame_Start
    );

endinterface

// File: rtl/seven_seg_scan_ctrl_timer.sv
// seg_scan_timer: loadable down-counter that holds at zero and flags terminal count.
module seg_scan_timer #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Load,
    input  logic [W-1:0] i_Value,
    output logic [W-1:0] o_Cnt,
    output logic         o_Tc
);

    logic [W-1:0] cnt_q, cnt_d;

    assign o_Cnt = cnt_q;
    assign o_Tc  = cnt_q == '0;

    always_comb begin
        cnt_d = i_Load ? i_Value : (o_Tc ? cnt_q : cnt_q - 1'b1);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) cnt_q <= RST_VAL;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: blanked multi-digit scan with frame-aligned shadow loading.
// Optional leading-zero suppression when SEVEN_SEG_LZ_BLANK_EN is defined.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    seven_seg_scan_ctrl_if.slave  bus
);

    localparam int IW = idx_w(NUM_DIGITS);
    localparam int CW = idx_w(DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES);
    localparam int DW = NIBBLE_W * NUM_DIGITS;
    localparam logic [CW-1:0] DW_M1 = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BL_M1 = CW'(BLANK_CYCLES - 1);

    scan_state_e           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         active_q, active_d, pend_q, pend_d;
    logic                  pend_v_q, pend_v_d, run_q, run_d, ack_q, ack_d;
    logic                  last, boundary, tmr_load, tc;
    logic [CW-1:0]         tmr_val, cnt;
    logic [NUM_DIGITS-1:0] keep;

    seg_scan_timer #(.W(CW), .RST_VAL(BL_M1)) u_timer (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Load (tmr_load),
        .i_Value(tmr_val),
        .o_Cnt  (cnt),
        .o_Tc   (tc)
    );

    // While disabled every cycle is a frame boundary, so loads still land promptly.
    always_comb begin
        last     = idx_q == IW'(NUM_DIGITS - 1);
        boundary = !bus.i_EN || (state_q == S_DRIVE && tc && last);
        state_d  = state_q;
        if (!bus.i_EN) state_d = S_BLANK;
        else if (tc)   state_d = (state_q == S_BLANK) ? S_DRIVE : S_BLANK;
        idx_d    = !bus.i_EN ? '0 : (tc && state_q == S_DRIVE) ? (last ? '0 : idx_q + 1'b1) : idx_q;
        tmr_load = !bus.i_EN || tc;
        tmr_val  = (bus.i_EN && state_q == S_BLANK) ? DW_M1 : BL_M1;
        active_d = (boundary && pend_v_q) ? pend_q : active_q;
        ack_d    = boundary && pend_v_q;
        pend_d   = bus.i_Load ? bus.i_Digits : pend_q;
        pend_v_d = bus.i_Load || (pend_v_q && !boundary);
        run_d    = bus.i_EN;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= S_BLANK;
            idx_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            run_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            run_q    <= run_d;
            ack_q    <= ack_d;
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) keep[k] = (k == 0) || (|(active_q >> (NIBBLE_W * k)));
    end
`else
    assign keep = '1;
`endif

    assign bus.o_EN          = run_q;
    assign bus.o_Binary_Num  = run_q ? active_q[idx_q*NIBBLE_W +: NIBBLE_W] : '0;
    assign bus.o_Digit_Sel   = (run_q && state_q == S_DRIVE) ? ((NUM_DIGITS'(1) << idx_q) & keep) : '0;
    assign bus.o_Frame_Start = run_q && state_q == S_DRIVE && idx_q == '0 && cnt == DW_M1;
    assign bus.o_Load_Ack    = ack_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed frame-by-frame checks with 4 digits, dwell 4, blank 2 (24-clock frame).
module tb_seven_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus();

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [10:0] obs;
    assign obs = {bus.o_Digit_Sel, bus.o_Binary_Num, bus.o_EN, bus.o_Frame_Start, bus.o_Load_Ack};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected {sel, nibble, en, frame_start, ack} at offset t of a frame starting at BLANK of digit 0.
    function automatic logic [10:0] model(input int t, input logic [15:0] d, input logic ack);
        int k;
        logic [3:0] sel;
        k   = t / 6;
        sel = (t % 6 < 2) ? 4'b0000 : (4'b0001 << k);
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (k > 0 && (d >> (4 * k)) == 16'h0000) sel = 4'b0000;
`endif
        return {sel, d[4*k +: 4], 1'b1, t == 2, ack};
    endfunction

    task automatic test_reset;
        rst = 1'b1; bus.i_EN = 1'b0; bus.i_Load = 1'b0; bus.i_Digits = '0;
        step; step;
        if (obs !== 11'b0) $display("FAIL reset_outputs got %b exp %b", obs, 11'b0); else passed++;
        checks++;
        rst = 1'b0; bus.i_EN = 1'b1; bus.i_Load = 1'b1; bus.i_Digits = 16'h1234;
        if (obs !== 11'b0) $display("FAIL reset_first_cycle got %b exp %b", obs, 11'b0); else passed++;
        checks++;
        step;
        bus.i_Load = 1'b0;
        for (int t = 1; t < 24; t++) begin
            if (obs !== model(t, 16'h0000, 1'b0)) $display("FAIL reset_frame t=%0d got %b exp %b", t, obs, model(t, 16'h0000, 1'b0)); else passed++;
            checks++;
            step;
        end
    endtask

    task automatic test_first_frame;
        for (int t = 0; t < 24; t++) begin
            if (obs !== model(t, 16'h1234, t == 0)) $display("FAIL frame_1234 t=%0d got %b exp %b", t, obs, model(t, 16'h1234, t == 0)); else passed++;
            checks++;
            step;
        end
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 24; t++) begin
            bus.i_Load   = (t == 0 || t == 5);
            bus.i_Digits = (t < 5) ? 16'hAAAA : 16'h5555;
            if (obs !== model(t, 16'h1234, 1'b0)) $display("FAIL double_load_hold t=%0d got %b exp %b", t, obs, model(t, 16'h1234, 1'b0)); else passed++;
            checks++;
            step;
        end
        bus.i_Load = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (obs !== model(t, 16'h5555, t == 0)) $display("FAIL double_load_new t=%0d got %b exp %b", t, obs, model(t, 16'h5555, t == 0)); else passed++;
            checks++;
            step;
        end
    endtask

    task automatic test_boundary_load;
        for (int t = 0; t < 48; t++) begin
            bus.i_Load   = (t == 23);
            bus.i_Digits = 16'h9876;
            if (obs !== model(t % 24, 16'h5555, 1'b0)) $display("FAIL boundary_hold t=%0d got %b exp %b", t, obs, model(t % 24, 16'h5555, 1'b0)); else passed++;
            checks++;
            step;
        end
        for (int t = 0; t < 24; t++) begin
            if (obs !== model(t, 16'h9876, t == 0)) $display("FAIL boundary_apply t=%0d got %b exp %b", t, obs, model(t, 16'h9876, t == 0)); else passed++;
            checks++;
            step;
        end
    endtask

    task automatic test_enable;
        for (int t = 0; t < 16; t++) begin
            if (obs !== model(t, 16'h9876, 1'b0)) $display("FAIL en_pre t=%0d got %b exp %b", t, obs, model(t, 16'h9876, 1'b0)); else passed++;
            checks++;
            if (t == 15) bus.i_EN = 1'b0;
            step;
        end
        if (obs !== 11'b0) $display("FAIL en_dark got %b exp %b", obs, 11'b0); else passed++;
        checks++;
        bus.i_Load = 1'b1; bus.i_Digits = 16'h4321;
        step;
        bus.i_Load = 1'b0;
        if (obs !== 11'b0) $display("FAIL en_pending got %b exp %b", obs, 11'b0); else passed++;
        checks++;
        step;
        if (obs !== 11'b1) $display("FAIL en_load_ack got %b exp %b", obs, 11'b1); else passed++;
        checks++;
        bus.i_EN = 1'b1;
        step;
        for (int t = 1; t < 24; t++) begin
            if (obs !== model(t, 16'h4321, 1'b0)) $display("FAIL en_restart t=%0d got %b exp %b", t, obs, model(t, 16'h4321, 1'b0)); else passed++;
            checks++;
            step;
        end
    endtask

    task automatic test_reset_mid;
        for (int t = 0; t < 9; t++) begin
            bus.i_Load   = (t == 3);
            bus.i_Digits = 16'hBEEF;
            if (obs !== model(t, 16'h4321, 1'b0)) $display("FAIL rst_pre t=%0d got %b exp %b", t, obs, model(t, 16'h4321, 1'b0)); else passed++;
            checks++;
            step;
        end
        bus.i_Load = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        if (obs !== 11'b0) $display("FAIL rst_mid_outputs got %b exp %b", obs, 11'b0); else passed++;
        checks++;
        step;
        for (int t = 1; t < 48; t++) begin
            if (obs !== model(t % 24, 16'h0000, 1'b0)) $display("FAIL rst_mid_frame t=%0d got %b exp %b", t, obs, model(t % 24, 16'h0000, 1'b0)); else passed++;
            checks++;
            step;
        end
    endtask

    task automatic test_leading_zero;
        for (int t = 0; t < 24; t++) begin
            bus.i_Load   = (t == 0);
            bus.i_Digits = 16'h0070;
            if (obs !== model(t, 16'h0000, 1'b0)) $display("FAIL lz_zero t=%0d got %b exp %b", t, obs, model(t, 16'h0000, 1'b0)); else passed++;
            checks++;
            step;
        end
        bus.i_Load = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (obs !== model(t, 16'h0070, t == 0)) $display("FAIL lz_0070 t=%0d got %b exp %b", t, obs, model(t, 16'h0070, t == 0)); else passed++;
            checks++;
            step;
        end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_back_to_back;
        test_boundary_load;
        test_enable;
        test_reset_mid;
        test_leading_zero;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
